// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external ALU between two requesters. A round-robin arbiter picks
//   a winner in IDLE, its operands are latched straight into the registered ALU
//   drive outputs, the ALU is given ALU_LAT cycles to settle, then C/zero are
//   captured and returned to the winner over a valid/ready response handshake.
//   Only one operation is outstanding at any time.
//
// Ports
//   clk, reset           : rising-edge clock, asynchronous active-low reset
//   reqN_valid/ready     : request handshake for requester N (ready is
//                          combinational and only high in IDLE for the winner)
//   reqN_a/b/op          : operands and ALUOp of requester N
//   rspN_valid/ready     : response handshake for requester N
//   rsp_c, rsp_zero      : captured ALU result, shared, qualified by rspN_valid
//   alu_a/b/op           : registered drive to the external ALU
//   alu_c, alu_zero      : result from the external ALU
//   busy                 : high whenever the FSM is not IDLE
module alu_share_arbiter #(
   parameter int ALU_LAT = 1,
   parameter int W       = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic [2:0]   req0_op,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic [2:0]   req1_op,
   output logic         rsp0_valid,
   input  logic         rsp0_ready,
   output logic         rsp1_valid,
   input  logic         rsp1_ready,
   output logic [W-1:0] rsp_c,
   output logic         rsp_zero,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [2:0]   alu_op,
   input  logic [W-1:0] alu_c,
   input  logic         alu_zero,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

   state_t     state;
   logic       owner;
   logic       last_grant;
   logic [3:0] cnt;
   logic       any_req;
   logic       grant;
   logic       rsp_take;

   // Arbitration: a lone request wins outright; on a tie the requester that
   // did not get the previous grant wins.
   always_comb begin
      any_req    = req0_valid | req1_valid;
      grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
      req0_ready = reset && (state == IDLE) && any_req && !grant;
      req1_ready = reset && (state == IDLE) && any_req && grant;
      rsp_take   = owner ? rsp1_ready : rsp0_ready;
      busy       = (state != IDLE);
   end

   // Operands are latched directly into the ALU drive registers at accept, so
   // they stay stable for all of EXEC and simply hold through RESP and IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         rsp_c      <= '0;
         rsp_zero   <= 1'b0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  alu_a      <= grant ? req1_a  : req0_a;
                  alu_b      <= grant ? req1_b  : req0_b;
                  alu_op     <= grant ? req1_op : req0_op;
                  owner      <= grant;
                  last_grant <= grant;
                  cnt        <= CNT_INIT;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  rsp_c      <= alu_c;
                  rsp_zero   <= alu_zero;
                  rsp0_valid <= !owner;
                  rsp1_valid <= owner;
                  state      <= RESP;
               end
            end
            RESP: begin
               // Only the owner's ready completes the handshake.
               if (rsp_take) begin
                  rsp0_valid <= 1'b0;
                  rsp1_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

   logic        clk;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]  req0_op, req1_op;
   logic        rsp0_ready, rsp1_ready;

   // ALU_LAT = 1 instance
   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, busy;
   logic [31:0] rsp_c, alu_a, alu_b, alu_c;
   logic [2:0]  alu_op;
   logic        alu_zero;

   // ALU_LAT = 4 instance
   logic        l4_req0_ready, l4_req1_ready, l4_rsp0_valid, l4_rsp1_valid, l4_rsp_zero, l4_busy;
   logic [31:0] l4_rsp_c, l4_alu_a, l4_alu_b, l4_alu_c;
   logic [2:0]  l4_alu_op;
   logic        l4_alu_zero;
   logic [3:0]  l4_age;
   logic [34:0] l4_prev;

   int vectors = 0;
   int errors  = 0;

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         default: return a ^ b;
      endcase
   endfunction

   assign alu_c    = alu_f(alu_a, alu_b, alu_op);
   assign alu_zero = (alu_c == 32'd0);

   // Slow ALU: output is unknown until its inputs have been stable for 4 cycles.
   always @(posedge clk) begin
      l4_prev <= {l4_alu_a[15:0], l4_alu_b[15:0], l4_alu_op};
      if ({l4_alu_a[15:0], l4_alu_b[15:0], l4_alu_op} != l4_prev) l4_age <= 4'd0;
      else if (l4_age != 4'd15) l4_age <= l4_age + 4'd1;
   end
   assign l4_alu_c    = (l4_age >= 4'd2) ? alu_f(l4_alu_a, l4_alu_b, l4_alu_op) : 32'hxxxxxxxx;
   assign l4_alu_zero = (l4_age >= 4'd2) ? (alu_f(l4_alu_a, l4_alu_b, l4_alu_op) == 32'd0) : 1'bx;

   alu_share_arbiter #(.ALU_LAT(1), .W(32)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_c(rsp_c), .rsp_zero(rsp_zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_zero(alu_zero),
      .busy(busy)
   );

   alu_share_arbiter #(.ALU_LAT(4), .W(32)) dut4 (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(l4_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(l4_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp0_valid(l4_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(l4_rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_c(l4_rsp_c), .rsp_zero(l4_rsp_zero),
      .alu_a(l4_alu_a), .alu_b(l4_alu_b), .alu_op(l4_alu_op), .alu_c(l4_alu_c), .alu_zero(l4_alu_zero),
      .busy(l4_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req0_op = '0;
      req1_a = '0; req1_b = '0; req1_op = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      tick();
      tick();
      vectors++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got %b exp 0", req0_ready); end
      vectors++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready got %b exp 0", req1_ready); end
      vectors++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp0_valid got %b exp 0", rsp0_valid); end
      vectors++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp1_valid got %b exp 0", rsp1_valid); end
      vectors++; if (rsp_c !== 32'd0) begin errors++; $display("FAIL reset_rsp_c got %h exp 0", rsp_c); end
      vectors++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_rsp_zero got %b exp 0", rsp_zero); end
      vectors++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'd0) begin errors++; $display("FAIL reset_alu got %h %h %h exp 0 0 0", alu_a, alu_b, alu_op); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_single();
      do_reset();
      req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'd0; req0_valid = 1'b1; rsp0_ready = 1'b1;
      #1;
      vectors++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_req0_ready got %b exp 1", req0_ready); end
      vectors++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_req1_ready got %b exp 0", req1_ready); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_c0 got %b exp 0", busy); end
      tick();
      req0_valid = 1'b0; req0_a = 32'd0;
      #1;
      vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_c1 got %b exp 1", busy); end
      vectors++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_rsp0_valid_c1 got %b exp 0", rsp0_valid); end
      vectors++; if (alu_a !== 32'd5 || alu_b !== 32'd3) begin errors++; $display("FAIL single_alu_ab got %h %h exp 5 3", alu_a, alu_b); end
      tick();
      vectors++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_valid_c2 got %b%b exp 10", rsp0_valid, rsp1_valid); end
      vectors++; if (rsp_c !== 32'd8) begin errors++; $display("FAIL single_rsp_c got %0d exp 8", rsp_c); end
      vectors++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL single_rsp_zero got %b exp 0", rsp_zero); end
      vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_c2 got %b exp 1", busy); end
      tick();
      vectors++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_idle_c3 got busy=%b rsp0_valid=%b exp 0 0", busy, rsp0_valid); end
   endtask

   task automatic test_back_to_back();
      logic w;
      logic [31:0] exp_c;
      reset = 1'b0;
      req0_a = 32'd10; req0_b = 32'd1; req0_op = 3'd0;
      req1_a = 32'd20; req1_b = 32'd4; req1_op = 3'd1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      #1;
      for (int g = 0; g < 4; g++) begin
         w = g[0];
         exp_c = w ? 32'd16 : 32'd11;
         vectors++; if (req0_ready !== !w || req1_ready !== w) begin errors++; $display("FAIL b2b_grant%0d got ready=%b%b exp %b%b", g, req0_ready, req1_ready, !w, w); end
         tick();
         tick();
         vectors++; if (rsp0_valid !== !w || rsp1_valid !== w) begin errors++; $display("FAIL b2b_rsp%0d got valid=%b%b exp %b%b", g, rsp0_valid, rsp1_valid, !w, w); end
         vectors++; if (rsp_c !== exp_c) begin errors++; $display("FAIL b2b_c%0d got %0d exp %0d", g, rsp_c, exp_c); end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      req1_a = 32'd7; req1_b = 32'd7; req1_op = 3'd1; req1_valid = 1'b1;
      rsp1_ready = 1'b0; rsp0_ready = 1'b1;
      #1;
      vectors++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_req1_ready got %b exp 1", req1_ready); end
      tick();
      req1_valid = 1'b0;
      req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'd0; req0_valid = 1'b1;
      #1;
      vectors++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_req0_ready_exec got %b exp 0", req0_ready); end
      tick();
      for (int i = 0; i < 5; i++) begin
         vectors++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL bp_hold%0d_valid got %b%b exp 01", i, rsp0_valid, rsp1_valid); end
         vectors++; if (rsp_c !== 32'd0 || rsp_zero !== 1'b1) begin errors++; $display("FAIL bp_hold%0d_result got c=%0d z=%b exp c=0 z=1", i, rsp_c, rsp_zero); end
         vectors++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d_req0_ready got %b exp 0", i, req0_ready); end
         tick();
      end
      rsp1_ready = 1'b1;
      #1;
      vectors++; if (rsp1_valid !== 1'b1) begin errors++; $display("FAIL bp_before_hs got %b exp 1", rsp1_valid); end
      tick();
      vectors++; if (rsp1_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_after_hs got valid=%b busy=%b exp 0 0", rsp1_valid, busy); end
      vectors++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_req0_ready_idle got %b exp 1", req0_ready); end
      req0_valid = 1'b0;
      tick();
   endtask

   task automatic test_lat4();
      int k;
      do_reset();
      req0_a = 32'd100; req0_b = 32'd23; req0_op = 3'd0; req0_valid = 1'b1; rsp0_ready = 1'b1;
      #1;
      vectors++; if (l4_req0_ready !== 1'b1) begin errors++; $display("FAIL lat4_req0_ready got %b exp 1", l4_req0_ready); end
      tick();
      req0_a = 32'd999; req0_b = 32'd0; req0_valid = 1'b0;
      #1;
      k = 0;
      while (l4_rsp0_valid !== 1'b1 && k < 20) begin
         vectors++; if (l4_alu_a !== 32'd100 || l4_alu_b !== 32'd23) begin errors++; $display("FAIL lat4_alu_stable%0d got %0d %0d exp 100 23", k, l4_alu_a, l4_alu_b); end
         tick();
         k++;
      end
      vectors++; if (k != 4) begin errors++; $display("FAIL lat4_latency got %0d cycles exp 4", k); end
      vectors++; if (l4_rsp_c !== 32'd123 || l4_rsp_zero !== 1'b0) begin errors++; $display("FAIL lat4_result got c=%0d z=%b exp c=123 z=0", l4_rsp_c, l4_rsp_zero); end
      tick();
      vectors++; if (l4_rsp0_valid !== 1'b0 || l4_busy !== 1'b0) begin errors++; $display("FAIL lat4_done got valid=%b busy=%b exp 0 0", l4_rsp0_valid, l4_busy); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'd3; req0_valid = 1'b1; rsp0_ready = 1'b1;
      #1;
      tick();
      req0_valid = 1'b0;
      #1;
      vectors++; if (busy !== 1'b1 || alu_op !== 3'd3) begin errors++; $display("FAIL rmid_exec got busy=%b op=%0d exp 1 3", busy, alu_op); end
      reset = 1'b0;
      #1;
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
      vectors++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'd0) begin errors++; $display("FAIL rmid_alu got %h %h %h exp 0 0 0", alu_a, alu_b, alu_op); end
      vectors++; if (rsp0_valid !== 1'b0 || rsp_c !== 32'd0 || rsp_zero !== 1'b0) begin errors++; $display("FAIL rmid_rsp got v=%b c=%h z=%b exp 0 0 0", rsp0_valid, rsp_c, rsp_zero); end
      tick();
      reset = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         vectors++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_after%0d got v=%b%b busy=%b exp 00 0", i, rsp0_valid, rsp1_valid, busy); end
         tick();
      end
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rmid_tie got %b%b exp 10", req0_ready, req1_ready); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_pulse();
      do_reset();
      req1_a = 32'd3; req1_b = 32'd4; req1_op = 3'd0; req1_valid = 1'b1; rsp1_ready = 1'b1;
      #1;
      vectors++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL pulse_req1_ready got %b exp 1", req1_ready); end
      tick();
      req1_valid = 1'b0;
      req0_a = 32'd9; req0_b = 32'd9; req0_op = 3'd0; req0_valid = 1'b1;
      #1;
      vectors++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL pulse_req0_ready got %b exp 0", req0_ready); end
      tick();
      req0_valid = 1'b0;
      #1;
      vectors++; if (rsp1_valid !== 1'b1 || rsp_c !== 32'd7) begin errors++; $display("FAIL pulse_rsp got v=%b c=%0d exp 1 7", rsp1_valid, rsp_c); end
      tick();
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL pulse_idle got busy=%b exp 0", busy); end
      tick();
      vectors++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL pulse_no_accept got busy=%b v0=%b exp 0 0", busy, rsp0_valid); end
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL pulse_tie got %b%b exp 10", req0_ready, req1_ready); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_lat4();
      test_reset_mid();
      test_pulse();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
